// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction fetch front-end between the PC generator, the
// icache and decode. Issues word-aligned fetch requests under a credit scheme
// so that every in-flight response is guaranteed a FIFO slot. Returned words
// are queued with their PC. A redirect flushes the FIFO, restarts fetch at
// the new PC, and discards responses still in flight from the old path.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   redirect_valid_i/_pc_i        branch/exception redirect and its target
//   icache_req_valid_o/_addr_o    fetch request (valid/ready with _ready_i)
//   icache_rsp_valid_i/_data_i    in-order instruction word returns
//   dec_valid_o/_instr_o/_pc_o    FIFO head presented to decode
//   dec_ready_i                   decode consumes the head
//   protocol_err_o                sticky: a response arrived with none owed
module ifetch_buffer #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_valid_o,
  output logic [31:0] icache_req_addr_o,
  input  logic        icache_req_ready_i,
  input  logic        icache_rsp_valid_i,
  input  logic [31:0] icache_rsp_data_i,
  output logic        dec_valid_o,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  input  logic        dec_ready_i,
  output logic        protocol_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard_cnt;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          perr;

  logic          accept;
  logic          rsp_ok;
  logic          push;
  logic          drop;
  logic          pop;
  logic [CW:0]   credit_sum;
  logic [31:0]   redirect_aligned;

  always_comb begin
    redirect_aligned = {redirect_pc_i[31:2], 2'b00};
    credit_sum       = {1'b0, count} + {1'b0, outstanding};

    // Reserving a FIFO slot for every in-flight request means a response can
    // always be pushed, so there is no response backpressure path.
    icache_req_valid_o = rst_ni && !redirect_valid_i
                         && (outstanding < MAX_L) && (credit_sum < DEPTH_L);
    icache_req_addr_o  = {fetch_pc[31:2], 2'b00};
    accept             = icache_req_valid_o && icache_req_ready_i;

    // A response is legitimate if something was owed, counting a request
    // accepted in this same cycle (zero-latency hit).
    rsp_ok = icache_rsp_valid_i && ((outstanding != '0) || accept);
    push   = rsp_ok && !redirect_valid_i && (discard_cnt == '0);
    drop   = rsp_ok && !redirect_valid_i && (discard_cnt != '0);

    outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_ok);

    dec_valid_o = rst_ni && (count != '0) && !redirect_valid_i;
    pop         = dec_valid_o && dec_ready_i;
    dec_instr_o = (count != '0) ? mem_instr[rptr] : 32'h0;
    dec_pc_o    = (count != '0) ? mem_pc[rptr]    : 32'h0;

    protocol_err_o = perr;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      resp_pc     <= {RESET_PC[31:2], 2'b00};
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      wptr        <= '0;
      rptr        <= '0;
      perr        <= 1'b0;
    end else begin
      if (icache_rsp_valid_i && !rsp_ok) perr <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid_i) begin
        // Everything still owed after this cycle belongs to the old path.
        count       <= '0;
        wptr        <= '0;
        rptr        <= '0;
        fetch_pc    <= redirect_aligned;
        resp_pc     <= redirect_aligned;
        discard_cnt <= outstanding_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          wptr    <= wptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (drop) discard_cnt <= discard_cnt - CW'(1);
        if (pop)  rptr        <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wptr] <= icache_rsp_data_i;
      mem_pc[wptr]    <= resp_pc;
    end
  end

endmodule

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction FIFO entries, a power of 2 and at least 2.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum icache requests in flight, from 1 to DEPTH.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; the only clock
- rst_ni  in  1  reset; synchronous, active-low
- redirect_valid_i  in  1  branch/exception redirect
- redirect_pc_i  in  32  new fetch PC
- icache_req_valid_o  out  1  fetch request to icache
- icache_req_addr_o  out  32  word-aligned fetch address
- icache_req_ready_i  in  1  icache accepts request
- icache_rsp_valid_i  in  1  icache returns one instruction word
- icache_rsp_data_i  in  32  instruction word
- dec_valid_o  out  1  instruction available to decode
- dec_instr_o  out  32  instruction at FIFO head
- dec_pc_o  out  32  PC of dec_instr_o
- dec_ready_i  in  1  decode consumes head
- protocol_err_o  out  1  sticky: response with nothing outstanding

Function
REQ-005 SHALL treat a request as accepted only in a cycle where icache_req_valid_o and icache_req_ready_i are both 1.
REQ-006 SHALL assert icache_req_valid_o = !redirect_valid_i && (outstanding < MAX_OUTSTANDING) && (count + outstanding < DEPTH); count = FIFO occupancy (credit scheme, no overflow).
REQ-007 SHALL drive icache_req_addr_o = fetch_pc with bits [1:0] always 0; once raised, valid and addr stay stable until accepted unless redirect_valid_i is 1.
REQ-008 SHALL advance fetch_pc by 4 on each accepted request; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-009 SHALL apply outstanding += 1 on acceptance and -= 1 on each icache_rsp_valid_i; both in one cycle leaves it unchanged.
REQ-010 SHALL assume responses return in request order, exactly one per accepted request, latency >= 0 cycles (same-cycle hit allowed).
REQ-011 SHALL, on a response with discard_cnt == 0 and no redirect, push {icache_rsp_data_i, resp_pc} into the FIFO and do resp_pc += 4 (same wrap as REQ-008).
REQ-012 SHALL have no bypass: a pushed word becomes visible on dec_* no earlier than the next cycle.
REQ-013 SHALL drive dec_valid_o = (count != 0) && !redirect_valid_i, with dec_instr_o/dec_pc_o = head entry, or 0 when count == 0.
REQ-014 SHALL pop the head when dec_valid_o && dec_ready_i; simultaneous push and pop leaves count unchanged (including at full).
REQ-015 SHALL, when redirect_valid_i == 1, in that cycle:
- empty the FIFO and clear its pointers
- set fetch_pc and resp_pc to {redirect_pc_i[31:2], 2'b00}
- issue no request and push no response
- set discard_cnt to the in-flight count after this cycle's response decrement
REQ-016 SHALL give redirect priority over every push, pop and request event in the same cycle.
REQ-017 SHALL, for a response with discard_cnt > 0 and no redirect, drop the data and decrement discard_cnt.
REQ-018 SHALL set protocol_err_o on icache_rsp_valid_i with outstanding == 0 and hold it until reset; such a response is ignored and counters do not underflow.
REQ-019 SHALL have no further states: behaviour is RUN plus redirect-flush handling by discard_cnt.

Reset
REQ-020 SHALL, at rst_ni == 0 on a clock edge, set:
- fetch_pc = resp_pc = RESET_PC
- count = outstanding = discard_cnt = 0
- protocol_err_o = 0
- FIFO pointers = 0
REQ-021 SHALL hold icache_req_valid_o and dec_valid_o at 0 throughout reset; reset mid-miss drops all in-flight state, and any late response then sets protocol_err_o.
REQ-022 SHALL raise the first request with addr = RESET_PC in the first cycle after rst_ni rises.

Verification
REQ-023 SHALL cover back-to-back hits: ready = 1, same-cycle responses, dec_ready = 1 -> addresses 0, 4, 8, ...; dec_pc matches; dec_valid rises one cycle after the first response.
REQ-024 SHALL cover backpressure: dec_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then icache_req_valid_o = 0; one pop reopens exactly one request.
REQ-025 SHALL cover redirect with 2 in flight: redirect to 32'h0000_1002 -> next request addr 32'h0000_1000; the 2 late responses are dropped; first dec_pc = 32'h0000_1000.
REQ-026 SHALL cover wrap: redirect to 32'hFFFF_FFFC -> requests 32'hFFFF_FFFC then 32'h0000_0000, and dec_pc follows the same sequence.
REQ-027 SHALL cover protocol error: a response with nothing outstanding -> protocol_err_o = 1 from the next cycle, sticky, FIFO unchanged.
REQ-028 SHALL cover reset mid-operation: assert rst_ni = 0 with FIFO at 3 entries -> next cycle all outputs 0; after release, first addr = RESET_PC.
